// File: rtl/core_types_pkg.sv
// Shared core types for the fetch predictor complex.
// Return-stack sizing, plus the checkpoint record that decode/BRU keep per branch.
package core_types_pkg;

  localparam int RAS_ENTRIES      = 8;
  localparam int LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES);
  localparam int RAS_TARGET_WIDTH = 31;

  localparam logic [LOG_RAS_ENTRIES:0] RAS_MAX_COUNT  = (LOG_RAS_ENTRIES+1)'(RAS_ENTRIES);
  localparam logic [LOG_RAS_ENTRIES:0] RAS_ZERO_COUNT = (LOG_RAS_ENTRIES+1)'(0);

  typedef struct packed {
    logic [LOG_RAS_ENTRIES-1:0] index;
    logic [LOG_RAS_ENTRIES:0]   count;
  } ras_checkpoint_t;

  // A restored count can never describe more live entries than the stack holds.
  function automatic logic [LOG_RAS_ENTRIES:0] ras_clamp_count(input logic [LOG_RAS_ENTRIES:0] count);
    if (count > RAS_MAX_COUNT) begin
      return RAS_MAX_COUNT;
    end else begin
      return count;
    end
  endfunction

endpackage

// File: rtl/ras.sv
// Return address stack: circular flop array with a top pointer and live-entry count.
// Outputs show pre-operation state so they double as the fetch-time checkpoint.
module ras
  import core_types_pkg::*;
(
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        ras_valid_i,
  input  logic                        ras_push_i,
  input  logic                        ras_pop_i,
  input  logic [RAS_TARGET_WIDTH-1:0] ras_push_target_i,
  output logic [RAS_TARGET_WIDTH-1:0] ras_ret_target_o,
  output logic [LOG_RAS_ENTRIES-1:0]  ras_index_o,
  output logic [LOG_RAS_ENTRIES:0]    ras_count_o,
  output logic                        ras_empty_o,
  input  logic                        update_valid_i,
  input  logic [LOG_RAS_ENTRIES-1:0]  update_ras_index_i,
  input  logic [LOG_RAS_ENTRIES:0]    update_ras_count_i
);

  localparam logic [LOG_RAS_ENTRIES-1:0] PTR_ONE   = LOG_RAS_ENTRIES'(1);
  localparam logic [LOG_RAS_ENTRIES:0]   COUNT_ONE = (LOG_RAS_ENTRIES+1)'(1);

  logic [RAS_TARGET_WIDTH-1:0] stack_r [RAS_ENTRIES];
  ras_checkpoint_t             cp_r;
  ras_checkpoint_t             cp_nxt_s;
  logic                        wr_en_s;
  logic [LOG_RAS_ENTRIES-1:0]  wr_idx_s;

  // Next pointer/count and stack write select; a restore drops any same-cycle fetch op.
  always_comb begin
    cp_nxt_s = cp_r;
    wr_en_s  = 1'b0;
    wr_idx_s = cp_r.index;
    if (update_valid_i) begin
      cp_nxt_s.index = update_ras_index_i;
      cp_nxt_s.count = ras_clamp_count(update_ras_count_i);
    end else if (ras_valid_i) begin
      case ({ras_push_i, ras_pop_i})
        2'b10: begin
          cp_nxt_s.index = cp_r.index + PTR_ONE;
          wr_en_s        = 1'b1;
          wr_idx_s       = cp_r.index + PTR_ONE;
          if (cp_r.count != RAS_MAX_COUNT) begin
            cp_nxt_s.count = cp_r.count + COUNT_ONE;
          end else begin
            cp_nxt_s.count = cp_r.count;
          end
        end
        2'b01: begin
          cp_nxt_s.index = cp_r.index - PTR_ONE;
          if (cp_r.count != RAS_ZERO_COUNT) begin
            cp_nxt_s.count = cp_r.count - COUNT_ONE;
          end else begin
            cp_nxt_s.count = cp_r.count;
          end
        end
        2'b11: begin
          wr_en_s = 1'b1;
        end
        default: begin
          wr_en_s = 1'b0;
        end
      endcase
    end else begin
      cp_nxt_s = cp_r;
    end
  end

  // Pointer and count state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cp_r <= '{index: '0, count: '0};
    end else begin
      cp_r <= cp_nxt_s;
    end
  end

  // Stack storage; a full-stack push naturally lands on the oldest slot.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        stack_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      stack_r[wr_idx_s] <= ras_push_target_i;
    end
  end

  assign ras_ret_target_o = stack_r[cp_r.index];
  assign ras_index_o      = cp_r.index;
  assign ras_count_o      = cp_r.count;
  assign ras_empty_o      = (cp_r.count == RAS_ZERO_COUNT);

endmodule

// File: tb/tb_ras.sv
// Self-checking bench for ras: directed scenarios plus randomized ops
// compared against an array/modulo reference model.
module tb_ras;
  import core_types_pkg::*;

  logic                        CLK = 1'b0;
  logic                        RST = 1'b1;
  logic                        ras_valid_i = 1'b0;
  logic                        ras_push_i = 1'b0;
  logic                        ras_pop_i = 1'b0;
  logic [RAS_TARGET_WIDTH-1:0] ras_push_target_i = '0;
  logic [RAS_TARGET_WIDTH-1:0] ras_ret_target_o;
  logic [LOG_RAS_ENTRIES-1:0]  ras_index_o;
  logic [LOG_RAS_ENTRIES:0]    ras_count_o;
  logic                        ras_empty_o;
  logic                        update_valid_i = 1'b0;
  logic [LOG_RAS_ENTRIES-1:0]  update_ras_index_i = '0;
  logic [LOG_RAS_ENTRIES:0]    update_ras_count_i = '0;

  ras dut (
    .CLK(CLK), .RST(RST),
    .ras_valid_i(ras_valid_i), .ras_push_i(ras_push_i), .ras_pop_i(ras_pop_i),
    .ras_push_target_i(ras_push_target_i),
    .ras_ret_target_o(ras_ret_target_o), .ras_index_o(ras_index_o),
    .ras_count_o(ras_count_o), .ras_empty_o(ras_empty_o),
    .update_valid_i(update_valid_i), .update_ras_index_i(update_ras_index_i),
    .update_ras_count_i(update_ras_count_i)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain array, integer pointer and count.
  int m_stk [RAS_ENTRIES];
  int m_ptr;
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".target"}, 32'(ras_ret_target_o), 32'(m_stk[m_ptr]));
    chk({tag, ".index"},  32'(ras_index_o),      32'(m_ptr));
    chk({tag, ".count"},  32'(ras_count_o),      32'(m_cnt));
    chk({tag, ".empty"},  32'(ras_empty_o),      32'(m_cnt == 0));
  endtask

  task automatic model_reset();
    for (int i = 0; i < RAS_ENTRIES; i++) m_stk[i] = 0;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    RST = 1'b1;
    ras_valid_i = 1'b0;
    update_valid_i = 1'b0;
    #2;
    model_reset();
    chk_model(tag);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, compare.
  task automatic step(input bit v, input bit push, input bit pop, input int tgt,
                      input bit uv, input int uidx, input int ucnt);
    ras_valid_i = v;
    ras_push_i = push;
    ras_pop_i = pop;
    ras_push_target_i = RAS_TARGET_WIDTH'(tgt);
    update_valid_i = uv;
    update_ras_index_i = LOG_RAS_ENTRIES'(uidx);
    update_ras_count_i = (LOG_RAS_ENTRIES+1)'(ucnt);
    @(posedge CLK);
    if (uv) begin
      m_ptr = uidx % RAS_ENTRIES;
      m_cnt = (ucnt > RAS_ENTRIES) ? RAS_ENTRIES : ucnt;
    end else if (v) begin
      if (push && pop) begin
        m_stk[m_ptr] = tgt;
      end else if (push) begin
        m_ptr = (m_ptr + 1) % RAS_ENTRIES;
        m_stk[m_ptr] = tgt;
        if (m_cnt < RAS_ENTRIES) m_cnt++;
      end else if (pop) begin
        m_ptr = (m_ptr + RAS_ENTRIES - 1) % RAS_ENTRIES;
        if (m_cnt > 0) m_cnt--;
      end
    end
    #1;
    chk_model("step");
  endtask

  task automatic push(input int t);
    step(1'b1, 1'b1, 1'b0, t, 1'b0, 0, 0);
  endtask

  task automatic pop();
    step(1'b1, 1'b0, 1'b1, 0, 1'b0, 0, 0);
  endtask

  task automatic expect3(input string tag, input int top, input int idx, input int cnt);
    chk({tag, ".top"}, 32'(ras_ret_target_o), 32'(top));
    chk({tag, ".idx"}, 32'(ras_index_o), 32'(idx));
    chk({tag, ".cnt"}, 32'(ras_count_o), 32'(cnt));
  endtask

  int cp_idx, cp_cnt;

  initial begin
    model_reset();
    #2;
    chk_model("reset_hold");
    expect3("reset", 0, 0, 0);
    chk("reset.empty", 32'(ras_empty_o), 32'd1);
    @(negedge CLK);
    RST = 1'b0;

    // Basic push/pop
    push(32'h100); push(32'h200); push(32'h300);
    expect3("push3", 32'h300, 3, 3);
    pop();
    expect3("pop1", 32'h200, 2, 2);

    // Overflow wrap: T9 overwrites T1
    do_reset("rst_ovf");
    for (int i = 1; i <= 9; i++) push(32'h1000 + i);
    expect3("ovf", 32'h1009, 1, 8);
    for (int i = 0; i < 7; i++) pop();
    chk("ovf_pop7.top", 32'(ras_ret_target_o), 32'h1002);

    // Underflow
    do_reset("rst_unf");
    pop();
    expect3("unf", 0, 7, 0);
    chk("unf.empty", 32'(ras_empty_o), 32'd1);
    push(32'hAAA);
    expect3("unf_push", 32'hAAA, 0, 1);
    chk("unf_push.empty", 32'(ras_empty_o), 32'd0);

    // Coroutine swap
    do_reset("rst_co");
    push(32'h10); push(32'h20);
    step(1'b1, 1'b1, 1'b1, 32'h55, 1'b0, 0, 0);
    expect3("coro", 32'h55, 2, 2);
    pop();
    chk("coro_pop.top", 32'(ras_ret_target_o), 32'h10);

    // Checkpoint restore beats a same-cycle push
    do_reset("rst_cp");
    push(32'h10); push(32'h20);
    cp_idx = int'(ras_index_o);
    cp_cnt = int'(ras_count_o);
    expect3("cp_take", 32'h20, 2, 2);
    pop(); push(32'h99); push(32'h77);
    expect3("cp_pre", 32'h77, 3, 3);
    step(1'b1, 1'b1, 1'b0, 32'h123, 1'b1, cp_idx, cp_cnt);
    expect3("cp_restore", 32'h99, 2, 2);

    // Restored count above capacity is clamped; valid low ignores push/pop
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, 5, 15);
    chk("clamp.cnt", 32'(ras_count_o), 32'd8);
    step(1'b0, 1'b1, 1'b0, 32'h7777, 1'b0, 0, 0);
    chk("novalid.idx", 32'(ras_index_o), 32'd5);

    // Randomized ops against the model
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
           int'($urandom & 32'h7FFF_FFFF),
           1'($urandom_range(0, 7) == 0),
           int'($urandom_range(0, RAS_ENTRIES - 1)),
           int'($urandom_range(0, 15)));
    end

    // Asynchronous reset mid-operation
    @(negedge CLK);
    ras_valid_i = 1'b1;
    ras_push_i = 1'b1;
    ras_pop_i = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    chk_model("async_rst");
    @(negedge CLK);
    RST = 1'b0;
    ras_valid_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ras.md
Name: ras

Overview:
- Return address stack for the fetch predictor complex.
- Sits directly downstream of the BTB lookup in the PC-generation stage. When the BTB pred_info marks a fetch-block slot as a link (call), a return, or a coroutine swap, pc_gen drives a push and/or pop here. On a return, the top-of-stack target is used as the next fetch PC.
- Decode/BRU restore the stack pointer and count on a mispredict, using a checkpoint taken at fetch.

Parameters:
- RAS_ENTRIES, 8, number of stack entries (power of 2).
- LOG_RAS_ENTRIES, $clog2(RAS_ENTRIES), stack index width.
- RAS_TARGET_WIDTH, 31, stored target width (PC[31:1], halfword-aligned).

Ports:
- CLK  input  1  clock
- RST  input  1  asynchronous, active-high reset
- ras_valid_i  input  1  fetch-side operation valid this cycle
- ras_push_i  input  1  push (link instruction)
- ras_pop_i  input  1  pop (return instruction)
- ras_push_target_i  input  RAS_TARGET_WIDTH  return address to push (PC+2/4, bits [31:1])
- ras_ret_target_o  output  RAS_TARGET_WIDTH  current top-of-stack target
- ras_index_o  output  LOG_RAS_ENTRIES  current stack pointer, the checkpoint for the fetched branch
- ras_count_o  output  LOG_RAS_ENTRIES+1  valid entry count, the checkpoint
- ras_empty_o  output  1  count == 0
- update_valid_i  input  1  mispredict restore
- update_ras_index_i  input  LOG_RAS_ENTRIES  restored stack pointer
- update_ras_count_i  input  LOG_RAS_ENTRIES+1  restored count

Behaviour:
- Storage and pointer:
  - Circular array stack[RAS_ENTRIES] of RAS_TARGET_WIDTH bits.
  - ptr always indexes the current top entry.
  - Pointer arithmetic is modulo RAS_ENTRIES; wrap-around is natural.
- Reset (RST high, async): all stack entries = 0, ptr = 0, count = 0. Reset values of outputs are therefore:
  - ras_ret_target_o = 0
  - ras_index_o = 0
  - ras_count_o = 0
  - ras_empty_o = 1
- Outputs: combinational from current state, zero latency.
  - ras_ret_target_o = stack[ptr]
  - ras_index_o = ptr
  - ras_count_o = count
  - Checkpoints and return targets always reflect state before this cycle's operation.
- Operations on the clock edge, when ras_valid_i=1 and update_valid_i=0:
  - push only: ptr <= ptr+1; stack[ptr+1] <= target; count <= min(count+1, RAS_ENTRIES). When full, the push overwrites the oldest entry.
  - pop only: ptr <= ptr-1; count <= max(count-1, 0). Popping an empty stack still moves ptr and keeps count at 0; the returned target is a stale entry, and pc_gen treats the return as unpredicted when ras_empty_o=1.
  - push+pop (coroutine): stack[ptr] <= target; ptr and count unchanged.
  - neither: no change.
- ras_valid_i=0: no state change regardless of push/pop.
- Restore:
  - update_valid_i=1: ptr <= update_ras_index_i; count <= update_ras_count_i.
  - Stack contents are not modified.
  - Restore has priority; a same-cycle fetch operation is dropped.
- Restored count greater than RAS_ENTRIES: clamp to RAS_ENTRIES.
- No stalls or backpressure; one operation per cycle.
- Reset mid-operation: reset wins immediately (async); in-flight push/pop is lost.

Decomposition:
- RAS_ENTRIES, LOG_RAS_ENTRIES and RAS_TARGET_WIDTH live in core_types_pkg (already present).
- Add to the package a packed typedef ras_checkpoint_t {index, count}, for reuse by the branch checkpoint storage in decode/BRU.
- Single flat module; the storage is small enough for a flop array, so no sub-module.

Test Plan:
- Reset -> ras_index_o=0, ras_count_o=0, ras_empty_o=1, ras_ret_target_o=0.
- Push 0x100, 0x200, 0x300 (valid=1) -> ret_target=0x300, index=3, count=3. Pop -> ret_target=0x200, index=2, count=2.
- Push 9 distinct targets T1..T9 into 8 entries -> count saturates at 8, index=1 (wrapped), top=T9. Pop 7 times -> top=T2 (T1 overwritten).
- From empty, pop -> count stays 0, index=7, ras_empty_o=1. Then push 0xAAA -> index=0, count=1, top=0xAAA.
- Push 0x10, 0x20, then push+pop with 0x55 -> index=2, count=2, top=0x55. Pop -> top=0x10.
- Checkpoint after pushing 0x10, 0x20 (index=2, count=2). Pop, push 0x99, push 0x77 (index=3, count=3, top=0x77). Then update_valid_i=1 with index=2, count=2, same cycle as a push -> index=2, count=2, push dropped, top=0x99 (slot 2 was overwritten, contents not restored).
